mem_access_stage: RTL and testbench

Memory-access stage directly downstream of the execution stage: owns the EX/MEM pipeline register, drives a multi-cycle data-memory handshake for loads and stores, and stalls the execution stage while an access is outstanding. It produces the MEM/WB register contents consumed by write-back, and provides the EX/MEM forwarding data, enable, and destination outputs used by the execution stage's forward unit.

---
 rtl/mem_access_stage.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access stage: owns the EX/MEM register, runs the data-memory handshake, fills MEM/WB.
// Latency: non-memory ops reach MEM/WB one edge after capture; memory ops one edge after dmem_ack.
// Backpressure: ex_ready drops while an access is outstanding and stays low once halted.
module mem_access_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [15:0] ex_instr,
  input  logic [15:0] ex_alu_out,
  input  logic [15:0] ex_set,
  input  logic [15:0] ex_btr,
  input  logic [15:0] ex_data_to_mem,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  input  logic        ex_halt,
  input  logic [2:0]  ex_dst_reg,
  input  logic [1:0]  ex_wb_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic        exmem_reg_write,
  output logic [2:0]  exmem_dst_reg,
  output logic [15:0] exmem_data,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic        wb_halt,
  output logic        wb_err,
  output logic [2:0]  wb_dst_reg,
  output logic [15:0] wb_data,
  output logic [15:0] wb_instr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t state, state_nxt;

  // EX/MEM pipeline register
  logic        em_valid;
  logic [15:0] em_instr;
  logic [15:0] em_alu_out;
  logic [15:0] em_set;
  logic [15:0] em_btr;
  logic [15:0] em_data_to_mem;
  logic        em_mem_read;
  logic        em_mem_write;
  logic        em_reg_write;
  logic        em_halt;
  logic [2:0]  em_dst_reg;
  logic [1:0]  em_wb_sel;

  logic        em_mem_op;
  logic        ex_mem_aligned;
  logic [15:0] em_result;

  // MEM/WB load controls produced by the FSM
  logic        wb_load;
  logic        wb_err_nxt;
  logic        wb_reg_write_nxt;
  logic [15:0] wb_data_nxt;
  logic        em_clear;

  assign em_mem_op      = em_mem_read | em_mem_write;
  assign ex_mem_aligned = (ex_mem_read | ex_mem_write) & ~ex_alu_out[0];

  // Result of the instruction in EX/MEM; a memory select falls back to the ALU value
  always_comb begin
    em_result = em_alu_out;
    case (em_wb_sel)
      2'd2:    em_result = em_set;
      2'd3:    em_result = em_btr;
      default: em_result = em_alu_out;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and MEM/WB load decisions
  always_comb begin
    state_nxt        = state;
    wb_load          = 1'b0;
    wb_err_nxt       = 1'b0;
    wb_reg_write_nxt = 1'b0;
    wb_data_nxt      = em_result;
    em_clear         = 1'b0;
    case (state)
      S_IDLE: begin
        if (em_valid) begin
          wb_load = 1'b1;
          if (em_mem_op) begin
            // A memory op still sitting here in IDLE was unaligned: report and stop
            wb_err_nxt       = 1'b1;
            wb_reg_write_nxt = 1'b0;
          end else begin
            wb_reg_write_nxt = em_reg_write;
          end
        end
        if (em_valid && (em_mem_op || em_halt)) begin
          state_nxt = S_HALTED;
        end else if (ex_valid && ex_mem_aligned) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          wb_load          = 1'b1;
          wb_reg_write_nxt = em_reg_write;
          if (em_mem_read) begin
            wb_data_nxt = dmem_rdata;
          end
          em_clear  = 1'b1;
          state_nxt = em_halt ? S_HALTED : S_IDLE;
        end
      end
      default: begin
        state_nxt = S_HALTED;
      end
    endcase
  end

  assign ex_ready = (state == S_IDLE);

  // Memory request is only driven while an access is outstanding
  assign dmem_req   = (state == S_WAIT);
  assign dmem_we    = dmem_req & em_mem_write;
  assign dmem_addr  = dmem_req ? em_alu_out     : 16'h0000;
  assign dmem_wdata = dmem_req ? em_data_to_mem : 16'h0000;

  // Loads are never forwarded out of EX/MEM; their data only exists after the access
  assign exmem_reg_write = em_valid & em_reg_write & ~em_mem_read;
  assign exmem_dst_reg   = em_dst_reg;
  assign exmem_data      = em_result;

  // EX/MEM register: capture when accepting, bubble when nothing is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_valid       <= 1'b0;
      em_instr       <= 16'h0000;
      em_alu_out     <= 16'h0000;
      em_set         <= 16'h0000;
      em_btr         <= 16'h0000;
      em_data_to_mem <= 16'h0000;
      em_mem_read    <= 1'b0;
      em_mem_write   <= 1'b0;
      em_reg_write   <= 1'b0;
      em_halt        <= 1'b0;
      em_dst_reg     <= 3'd0;
      em_wb_sel      <= 2'd0;
    end else if (ex_ready) begin
      em_valid <= ex_valid;
      if (ex_valid) begin
        em_instr       <= ex_instr;
        em_alu_out     <= ex_alu_out;
        em_set         <= ex_set;
        em_btr         <= ex_btr;
        em_data_to_mem <= ex_data_to_mem;
        em_mem_read    <= ex_mem_read;
        em_mem_write   <= ex_mem_write;
        em_reg_write   <= ex_reg_write;
        em_halt        <= ex_halt;
        em_dst_reg     <= ex_dst_reg;
        em_wb_sel      <= ex_wb_sel;
      end
    end else if (em_clear) begin
      em_valid <= 1'b0;
    end
  end

  // MEM/WB register: valid pulses on each load, payload holds between loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_halt      <= 1'b0;
      wb_err       <= 1'b0;
      wb_dst_reg   <= 3'd0;
      wb_data      <= 16'h0000;
      wb_instr     <= 16'h0000;
    end else begin
      wb_valid <= wb_load;
      if (wb_load) begin
        wb_reg_write <= wb_reg_write_nxt;
        wb_halt      <= em_halt;
        wb_err       <= wb_err_nxt;
        wb_dst_reg   <= em_dst_reg;
        wb_data      <= wb_data_nxt;
        wb_instr     <= em_instr;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a transaction-level reference model.
// The model tracks which instruction the stage holds and what write-back should see.
// A bench-side memory acknowledges after a random 1..4 cycle latency.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [15:0] ex_instr, ex_alu_out, ex_set, ex_btr, ex_data_to_mem;
  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_halt;
  logic [2:0]  ex_dst_reg;
  logic [1:0]  ex_wb_sel;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic        exmem_reg_write;
  logic [2:0]  exmem_dst_reg;
  logic [15:0] exmem_data;
  logic        wb_valid, wb_reg_write, wb_halt, wb_err;
  logic [2:0]  wb_dst_reg;
  logic [15:0] wb_data, wb_instr;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] alu;
    logic [15:0] set_v;
    logic [15:0] btr;
    logic [15:0] wd;
    logic        rd;
    logic        wr;
    logic        rw;
    logic        halt;
    logic [2:0]  dst;
    logic [1:0]  sel;
  } ins_t;

  ins_t cur;

  assign ex_instr       = cur.instr;
  assign ex_alu_out     = cur.alu;
  assign ex_set         = cur.set_v;
  assign ex_btr         = cur.btr;
  assign ex_data_to_mem = cur.wd;
  assign ex_mem_read    = cur.rd;
  assign ex_mem_write   = cur.wr;
  assign ex_reg_write   = cur.rw;
  assign ex_halt        = cur.halt;
  assign ex_dst_reg     = cur.dst;
  assign ex_wb_sel      = cur.sel;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_instr(ex_instr), .ex_alu_out(ex_alu_out), .ex_set(ex_set), .ex_btr(ex_btr),
    .ex_data_to_mem(ex_data_to_mem),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_halt(ex_halt),
    .ex_dst_reg(ex_dst_reg), .ex_wb_sel(ex_wb_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .exmem_reg_write(exmem_reg_write), .exmem_dst_reg(exmem_dst_reg), .exmem_data(exmem_data),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_halt(wb_halt), .wb_err(wb_err),
    .wb_dst_reg(wb_dst_reg), .wb_data(wb_data), .wb_instr(wb_instr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the stage holds and what write-back last received
  localparam int M_FLOW = 0;  // accepting from EX
  localparam int M_MEM  = 1;  // access outstanding
  localparam int M_STOP = 2;  // halted until reset

  int          mode;
  logic        have;
  ins_t        em;
  logic        m_wbv, m_wbrw, m_wbh, m_wbe;
  logic [2:0]  m_wbdst;
  logic [15:0] m_wbdata, m_wbinstr;
  int          lat, wcnt;

  function automatic logic [15:0] res_of(input ins_t i);
    if (i.sel == 2'd2) return i.set_v;
    if (i.sel == 2'd3) return i.btr;
    return i.alu;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    int k;
    k       = $urandom_range(0, 15);
    i.instr = 16'($urandom);
    i.alu   = 16'($urandom);
    i.set_v = 16'($urandom);
    i.btr   = 16'($urandom);
    i.wd    = 16'($urandom);
    i.dst   = 3'($urandom);
    i.halt  = ($urandom_range(0, 59) == 0);
    i.rd    = 1'b0;
    i.wr    = 1'b0;
    if (k < 4) begin
      i.rd  = 1'b1;
      i.rw  = 1'b1;
      i.sel = 2'd1;
    end else if (k < 6) begin
      i.wr  = 1'b1;
      i.rw  = 1'b0;
      i.sel = 2'($urandom);
    end else begin
      i.rw  = 1'($urandom);
      i.sel = 2'($urandom);
    end
    if ((i.rd || i.wr) && $urandom_range(0, 29) != 0) i.alu[0] = 1'b0;
    return i;
  endfunction

  task automatic model_reset();
    mode      = M_FLOW;
    have      = 1'b0;
    em        = '0;
    m_wbv     = 1'b0;
    m_wbrw    = 1'b0;
    m_wbh     = 1'b0;
    m_wbe     = 1'b0;
    m_wbdst   = 3'd0;
    m_wbdata  = 16'h0000;
    m_wbinstr = 16'h0000;
  endtask

  task automatic put_wb(input ins_t i, input logic [15:0] d, input logic err, input logic rw);
    m_wbv     = 1'b1;
    m_wbdata  = d;
    m_wbe     = err;
    m_wbrw    = rw;
    m_wbh     = i.halt;
    m_wbdst   = i.dst;
    m_wbinstr = i.instr;
  endtask

  // One clock edge of the reference model, using the inputs presented this cycle
  task automatic model_step();
    bit stop;
    if (mode == M_STOP) begin
      m_wbv = 1'b0;
    end else if (mode == M_MEM) begin
      if (dmem_ack) begin
        put_wb(em, em.rd ? dmem_rdata : res_of(em), 1'b0, em.rw);
        have = 1'b0;
        mode = em.halt ? M_STOP : M_FLOW;
      end else begin
        m_wbv = 1'b0;
      end
    end else begin
      stop = 0;
      if (have) begin
        if (em.rd || em.wr) begin
          put_wb(em, res_of(em), 1'b1, 1'b0);
          stop = 1;
        end else begin
          put_wb(em, res_of(em), 1'b0, em.rw);
          stop = em.halt;
        end
      end else begin
        m_wbv = 1'b0;
      end
      have = ex_valid;
      if (ex_valid) em = cur;
      if (stop) begin
        mode = M_STOP;
      end else if (ex_valid && (cur.rd || cur.wr) && !cur.alu[0]) begin
        mode = M_MEM;
        lat  = $urandom_range(1, 4);
        wcnt = 0;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("ex_ready", ex_ready, mode == M_FLOW);
    check_eq("dmem_req", dmem_req, mode == M_MEM);
    if (mode == M_MEM) begin
      check_eq("dmem_we", dmem_we, em.wr);
      check_eq("dmem_addr", dmem_addr, em.alu);
      check_eq("dmem_wdata", dmem_wdata, em.wd);
    end
    check_eq("wb_valid", wb_valid, m_wbv);
    check_eq("wb_reg_write", wb_reg_write, m_wbrw);
    check_eq("wb_halt", wb_halt, m_wbh);
    check_eq("wb_err", wb_err, m_wbe);
    check_eq("wb_dst_reg", wb_dst_reg, m_wbdst);
    check_eq("wb_data", wb_data, m_wbdata);
    check_eq("wb_instr", wb_instr, m_wbinstr);
    check_eq("exmem_reg_write", exmem_reg_write, have && em.rw && !em.rd);
    check_eq("exmem_dst_reg", exmem_dst_reg, em.dst);
    check_eq("exmem_data", exmem_data, res_of(em));
  endtask

  // Memory responder and EX source for the coming cycle
  task automatic drive_inputs(input bit taken);
    dmem_rdata = 16'($urandom);
    if (mode == M_MEM) begin
      wcnt++;
      dmem_ack = (wcnt == lat);
    end else begin
      dmem_ack = ($urandom_range(0, 5) == 0);
    end
    if (taken || !ex_valid) begin
      ex_valid = ($urandom_range(0, 4) != 0);
      cur      = rand_ins();
    end
  endtask

  task automatic run_cycle();
    bit taken;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    taken = (mode == M_FLOW) && ex_valid;
    model_step();
    #1;
    drive_inputs(taken);
  endtask

  task automatic reset_checks();
    check_eq("rst_dmem_req", dmem_req, 1'b0);
    check_eq("rst_ex_ready", ex_ready, 1'b1);
    check_eq("rst_wb_valid", wb_valid, 1'b0);
    check_eq("rst_wb_err", wb_err, 1'b0);
    check_eq("rst_exmem_reg_write", exmem_reg_write, 1'b0);
    check_eq("rst_wb_data", wb_data, 16'h0000);
  endtask

  initial begin
    rst_n      = 1'b0;
    ex_valid   = 1'b0;
    cur        = '0;
    dmem_ack   = 1'b0;
    dmem_rdata = 16'h0000;
    wcnt       = 0;
    lat        = 1;
    model_reset();
    #1;
    reset_checks();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_inputs(1'b1);

    for (int ep = 0; ep < 24; ep++) begin
      int len;
      len = $urandom_range(30, 150);
      for (int c = 0; c < len; c++) run_cycle();
      // Prefer to pull reset while an access is outstanding
      for (int j = 0; j < 20 && mode != M_MEM && mode != M_STOP; j++) run_cycle();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      reset_checks();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_inputs(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
